// File: rtl/sdram_scheduler.sv
// Command-level SDRAM scheduler: grants the pins to the read or write burst engine
// round-robin and interleaves periodic PRECHARGE-ALL + AUTO REFRESH sequences.
module sdram_scheduler #(
  parameter int unsigned REFRESH_INTERVAL = 1560,
  parameter int unsigned TRP              = 2,
  parameter int unsigned TRFC             = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [13:0] rd_address,
  input  logic [23:0] rd_count,
  output logic        rd_ack,
  input  logic        wr_req,
  input  logic [13:0] wr_address,
  input  logic [23:0] wr_count,
  output logic        wr_ack,
  output logic        rd_en,
  output logic [13:0] rd_read_address,
  output logic [23:0] rd_read_count,
  input  logic        rd_done,
  input  logic [3:0]  rd_cmd,
  input  logic [11:0] rd_addr,
  input  logic [1:0]  rd_bank,
  output logic        wr_en,
  output logic [13:0] wr_write_address,
  output logic [23:0] wr_write_count,
  input  logic        wr_done,
  input  logic [3:0]  wr_cmd,
  input  logic [11:0] wr_addr,
  input  logic [1:0]  wr_bank,
  output logic [3:0]  sdram_cmd,
  output logic [11:0] sdram_addr,
  output logic [1:0]  sdram_bank,
  output logic        busy,
  output logic        refresh_late
);

  localparam logic [3:0]  CmdNop      = 4'b0111;
  localparam logic [3:0]  CmdPre      = 4'b0010;
  localparam logic [3:0]  CmdRef      = 4'b0001;
  localparam logic [15:0] TimerReload = 16'(REFRESH_INTERVAL - 1);
  localparam logic [7:0]  TrpLast     = 8'(TRP - 1);
  localparam logic [7:0]  TrfcLast    = 8'(TRFC - 1);

  typedef enum logic [3:0] {
    StIdle, StRdStart, StRdBusy, StWrStart, StWrBusy,
    StRefPre, StRefTrp, StRefAr, StRefTrfc
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        ref_pending_q, ref_pending_d;
  logic        last_wr_q, last_wr_d;
  logic        rd_ack_d, wr_ack_d, rd_en_d, wr_en_d, late_d;
  logic [13:0] rd_address_d, wr_address_d;
  logic [23:0] rd_count_d, wr_count_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [11:0] addr_q, addr_d;
  logic [1:0]  bank_q, bank_d;
  logic        expire, ref_start, rd_ok, wr_ok, pick_rd;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    last_wr_d    = last_wr_q;
    rd_ack_d     = 1'b0;
    wr_ack_d     = 1'b0;
    rd_en_d      = 1'b0;
    wr_en_d      = 1'b0;
    rd_address_d = rd_read_address;
    rd_count_d   = rd_read_count;
    wr_address_d = wr_write_address;
    wr_count_d   = wr_write_count;

    expire  = (timer_q == 16'd0);
    timer_d = expire ? TimerReload : timer_q - 16'd1;

    // A request whose ack is still high was just served as zero-count; do not grant it twice.
    rd_ok   = rd_req & ~rd_ack;
    wr_ok   = wr_req & ~wr_ack;
    pick_rd = rd_ok & (~wr_ok | last_wr_q);

    case (state_q)
      StIdle: begin
        if (ref_pending_q) begin
          state_d = StRefPre;
        end else if (pick_rd) begin
          rd_ack_d  = 1'b1;
          last_wr_d = 1'b0;
          if (rd_count != 24'd0) begin
            rd_address_d = rd_address;
            rd_count_d   = rd_count;
            state_d      = StRdStart;
          end
        end else if (wr_ok) begin
          wr_ack_d  = 1'b1;
          last_wr_d = 1'b1;
          if (wr_count != 24'd0) begin
            wr_address_d = wr_address;
            wr_count_d   = wr_count;
            state_d      = StWrStart;
          end
        end
      end
      StRdStart: begin
        rd_en_d = 1'b1;
        state_d = StRdBusy;
      end
      StRdBusy:  if (rd_done) state_d = StIdle;
      StWrStart: begin
        wr_en_d = 1'b1;
        state_d = StWrBusy;
      end
      StWrBusy:  if (wr_done) state_d = StIdle;
      StRefPre: begin
        wait_cnt_d = 8'd0;
        state_d    = StRefTrp;
      end
      StRefTrp: begin
        if (wait_cnt_q == TrpLast) state_d = StRefAr;
        else wait_cnt_d = wait_cnt_q + 8'd1;
      end
      StRefAr: begin
        wait_cnt_d = 8'd0;
        state_d    = StRefTrfc;
      end
      StRefTrfc: begin
        if (wait_cnt_q == TrfcLast) state_d = StIdle;
        else wait_cnt_d = wait_cnt_q + 8'd1;
      end
      default: state_d = StIdle;
    endcase

    // A new expiry always wins over the clear on REF_PRE entry.
    ref_start     = (state_q == StIdle) & ref_pending_q;
    ref_pending_d = expire | (ref_pending_q & ~ref_start);
    late_d        = expire & ref_pending_q & ~ref_start;

    cmd_d  = CmdNop;
    addr_d = 12'd0;
    bank_d = 2'd0;
    case (state_d)
      StRefPre: begin
        cmd_d  = CmdPre;
        addr_d = 12'h400;
      end
      StRefAr: cmd_d = CmdRef;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      timer_q          <= TimerReload;
      wait_cnt_q       <= 8'd0;
      ref_pending_q    <= 1'b0;
      last_wr_q        <= 1'b1;
      rd_ack           <= 1'b0;
      wr_ack           <= 1'b0;
      rd_en            <= 1'b0;
      wr_en            <= 1'b0;
      refresh_late     <= 1'b0;
      rd_read_address  <= 14'd0;
      rd_read_count    <= 24'd0;
      wr_write_address <= 14'd0;
      wr_write_count   <= 24'd0;
      cmd_q            <= CmdNop;
      addr_q           <= 12'd0;
      bank_q           <= 2'd0;
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      wait_cnt_q       <= wait_cnt_d;
      ref_pending_q    <= ref_pending_d;
      last_wr_q        <= last_wr_d;
      rd_ack           <= rd_ack_d;
      wr_ack           <= wr_ack_d;
      rd_en            <= rd_en_d;
      wr_en            <= wr_en_d;
      refresh_late     <= late_d;
      rd_read_address  <= rd_address_d;
      rd_read_count    <= rd_count_d;
      wr_write_address <= wr_address_d;
      wr_write_count   <= wr_count_d;
      cmd_q            <= cmd_d;
      addr_q           <= addr_d;
      bank_q           <= bank_d;
    end
  end

  // Engines own the pins combinationally while their burst runs.
  always_comb begin
    sdram_cmd  = cmd_q;
    sdram_addr = addr_q;
    sdram_bank = bank_q;
    if (state_q == StRdBusy) begin
      sdram_cmd  = rd_cmd;
      sdram_addr = rd_addr;
      sdram_bank = rd_bank;
    end else if (state_q == StWrBusy) begin
      sdram_cmd  = wr_cmd;
      sdram_addr = wr_addr;
      sdram_bank = wr_bank;
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_sdram_scheduler.sv
// Bench for sdram_scheduler: cycle-indexed expectation timeline built from grant/refresh
// event times, checked every cycle; a second instance with a short refresh interval idles.
module tb_sdram_scheduler;
  localparam int TRP = 2;
  localparam int TRFC = 7;
  localparam int SHORT_IV = 20;
  localparam int REF_LEN = 2 + TRP + TRFC;
  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam int OWN_RD = 1, OWN_WR = 2, OWN_PRE = 3, OWN_AR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        rd_req = 0, wr_req = 0, rd_done = 0, wr_done = 0;
  logic [13:0] rd_address = 0, wr_address = 0;
  logic [23:0] rd_count = 0, wr_count = 0;
  logic [3:0]  rd_cmd = NOP, wr_cmd = NOP;
  logic [11:0] rd_addr = 0, wr_addr = 0;
  logic [1:0]  rd_bank = 0, wr_bank = 0;
  logic        rd_ack, wr_ack, rd_en, wr_en, busy, refresh_late;
  logic [13:0] rd_read_address, wr_write_address;
  logic [23:0] rd_read_count, wr_write_count;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_bank;

  logic        d20_rd_ack, d20_wr_ack, d20_rd_en, d20_wr_en, d20_busy, d20_late;
  logic [13:0] d20_rda, d20_wra;
  logic [23:0] d20_rdn, d20_wrn;
  logic [3:0]  d20_cmd;
  logic [11:0] d20_addr;
  logic [1:0]  d20_bank;

  sdram_scheduler dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_address(rd_address), .rd_count(rd_count), .rd_ack(rd_ack),
    .wr_req(wr_req), .wr_address(wr_address), .wr_count(wr_count), .wr_ack(wr_ack),
    .rd_en(rd_en), .rd_read_address(rd_read_address), .rd_read_count(rd_read_count),
    .rd_done(rd_done), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
    .wr_en(wr_en), .wr_write_address(wr_write_address), .wr_write_count(wr_write_count),
    .wr_done(wr_done), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
    .busy(busy), .refresh_late(refresh_late)
  );

  sdram_scheduler #(.REFRESH_INTERVAL(SHORT_IV)) dut20 (
    .clk(clk), .rst(rst),
    .rd_req(1'b0), .rd_address(14'd0), .rd_count(24'd0), .rd_ack(d20_rd_ack),
    .wr_req(1'b0), .wr_address(14'd0), .wr_count(24'd0), .wr_ack(d20_wr_ack),
    .rd_en(d20_rd_en), .rd_read_address(d20_rda), .rd_read_count(d20_rdn),
    .rd_done(1'b0), .rd_cmd(4'b0011), .rd_addr(12'h123), .rd_bank(2'd1),
    .wr_en(d20_wr_en), .wr_write_address(d20_wra), .wr_write_count(d20_wrn),
    .wr_done(1'b0), .wr_cmd(4'b0100), .wr_addr(12'h321), .wr_bank(2'd2),
    .sdram_cmd(d20_cmd), .sdram_addr(d20_addr), .sdram_bank(d20_bank),
    .busy(d20_busy), .refresh_late(d20_late)
  );

  int cyc;
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;
  int rd_todo = 0, wr_todo = 0, rd_acked = 0, wr_acked = 0;
  int rd_len = 4, wr_len = 4;

  // Expected timeline, keyed by cycle index (cycle k = values after posedge k).
  bit          exp_rdack[int], exp_wrack[int], exp_rden[int], exp_wren[int];
  bit          exp_late[int], exp_busy[int];
  int          exp_own[int];
  logic [13:0] exp_rda[int], exp_wra[int];
  logic [23:0] exp_rdn[int], exp_wrn[int];

  task automatic check(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, k, act, req);
    end
  endtask

  task automatic clear_exp();
    exp_rdack.delete(); exp_wrack.delete(); exp_rden.delete(); exp_wren.delete();
    exp_late.delete(); exp_busy.delete(); exp_own.delete();
    exp_rda.delete(); exp_wra.delete(); exp_rdn.delete(); exp_wrn.delete();
  endtask

  // Request sampled at edge s: ack in s, en in s+1, engine on pins s+1..s+1+len, IDLE after.
  task automatic expect_grant(input bit wr, input int s, input int len,
                              input logic [13:0] a, input logic [23:0] n);
    if (wr) exp_wrack[s] = 1'b1;
    else exp_rdack[s] = 1'b1;
    if (n == 24'd0) return;
    if (wr) begin
      exp_wren[s + 1] = 1'b1; exp_wra[s + 1] = a; exp_wrn[s + 1] = n;
    end else begin
      exp_rden[s + 1] = 1'b1; exp_rda[s + 1] = a; exp_rdn[s + 1] = n;
    end
    exp_busy[s] = 1'b1;
    for (int i = s + 1; i <= s + 1 + len; i++) begin
      exp_busy[i] = 1'b1;
      exp_own[i] = wr ? OWN_WR : OWN_RD;
    end
  endtask

  task automatic expect_refresh(input int p);
    for (int i = 0; i < REF_LEN; i++) exp_busy[p + i] = 1'b1;
    exp_own[p] = OWN_PRE;
    exp_own[p + 1 + TRP] = OWN_AR;
  endtask

  task automatic at_cycle(input int n);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    clear_exp();
    rd_todo = rd_acked;
    wr_todo = wr_acked;
    @(negedge clk);
    #1;
    check("reset_cmd", cyc, sdram_cmd, NOP);
    check("reset_addr_bank", cyc, {sdram_addr, sdram_bank}, 0);
    check("reset_pulses", cyc, {rd_ack, wr_ack, rd_en, wr_en, refresh_late, busy}, 0);
    check("reset_rd_latch", cyc, {rd_read_address, rd_read_count}, 0);
    check("reset_wr_latch", cyc, {wr_write_address, wr_write_count}, 0);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // Requester stub: holds each request until it has collected the wanted acks.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (rd_ack) rd_acked++;
      if (wr_ack) wr_acked++;
    end
    @(posedge clk);
    #2;
    rd_req = (rd_acked < rd_todo);
    wr_req = (wr_acked < wr_todo);
  end

  // Engine stubs: done arrives len cycles after the en pulse.
  initial forever begin
    @(negedge clk);
    if (rd_en && !rst) begin
      repeat (rd_len) @(posedge clk);
      #1 rd_done = 1'b1;
      @(posedge clk);
      #1 rd_done = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (wr_en && !rst) begin
      repeat (wr_len) @(posedge clk);
      #1 wr_done = 1'b1;
      @(posedge clk);
      #1 wr_done = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #3;
    rd_cmd = 4'(cyc * 3 + 1);
    rd_addr = 12'(cyc * 7);
    rd_bank = 2'(cyc);
    wr_cmd = 4'(cyc * 5 + 2);
    wr_addr = 12'(cyc * 11 + 5);
    wr_bank = 2'(cyc + 1);
  end

  initial forever begin
    int k, own, ph;
    logic [3:0] e_cmd;
    logic [11:0] e_addr;
    logic [1:0] e_bank;
    @(negedge clk);
    if (!rst && cyc > 0) begin
      k = cyc;
      own = exp_own.exists(k) ? exp_own[k] : 0;
      e_cmd = NOP; e_addr = 12'd0; e_bank = 2'd0;
      case (own)
        OWN_RD:  begin e_cmd = rd_cmd; e_addr = rd_addr; e_bank = rd_bank; end
        OWN_WR:  begin e_cmd = wr_cmd; e_addr = wr_addr; e_bank = wr_bank; end
        OWN_PRE: begin e_cmd = PRE; e_addr = 12'h400; end
        OWN_AR:  e_cmd = AREF;
        default: ;
      endcase
      check("sdram_cmd", k, sdram_cmd, e_cmd);
      check("sdram_addr", k, sdram_addr, e_addr);
      check("sdram_bank", k, sdram_bank, e_bank);
      check("rd_ack", k, rd_ack, exp_rdack.exists(k));
      check("wr_ack", k, wr_ack, exp_wrack.exists(k));
      check("rd_en", k, rd_en, exp_rden.exists(k));
      check("wr_en", k, wr_en, exp_wren.exists(k));
      check("refresh_late", k, refresh_late, exp_late.exists(k));
      check("busy", k, busy, exp_busy.exists(k));
      if (exp_rda.exists(k)) begin
        check("rd_read_address", k, rd_read_address, exp_rda[k]);
        check("rd_read_count", k, rd_read_count, exp_rdn[k]);
      end
      if (exp_wra.exists(k)) begin
        check("wr_write_address", k, wr_write_address, exp_wra[k]);
        check("wr_write_count", k, wr_write_count, exp_wrn[k]);
      end
      // Idle short-interval instance: refresh starts one cycle after every expiry.
      ph = (k > SHORT_IV) ? (k - 1) % SHORT_IV : -1;
      check("d20_cmd", k, d20_cmd, (ph == 0) ? PRE : (ph == 1 + TRP) ? AREF : NOP);
      check("d20_addr", k, {d20_addr, d20_bank}, (ph == 0) ? {12'h400, 2'd0} : 14'd0);
      check("d20_busy", k, d20_busy, ph >= 0 && ph < REF_LEN);
      check("d20_quiet", k, {d20_rd_ack, d20_wr_ack, d20_rd_en, d20_wr_en, d20_late}, 0);
      check("d20_latch", k, {d20_rda, d20_rdn, d20_wra, d20_wrn} == '0, 1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected end", cyc);
    $fatal(1);
  end

  initial begin
    do_reset();

    // Single read.
    at_cycle(3);
    rd_address = 14'h1ABC; rd_count = 24'd5; rd_len = 6; rd_todo = rd_acked + 1;
    expect_grant(0, 4, 6, 14'h1ABC, 24'd5);
    at_cycle(4);
    check("lit_rd_ack", cyc, rd_ack, 1);
    at_cycle(5);
    check("lit_rd_en", cyc, rd_en, 1);
    check("lit_rd_addr", cyc, rd_read_address, 14'h1ABC);
    check("lit_rd_count", cyc, rd_read_count, 24'd5);
    at_cycle(14);

    // Both requests held: R,W,R,W with a 13-cycle grant period.
    do_reset();
    at_cycle(3);
    rd_address = 14'h0123; rd_count = 24'd8; wr_address = 14'h2345; wr_count = 24'd9;
    rd_len = 10; wr_len = 10; rd_todo = rd_acked + 2; wr_todo = wr_acked + 2;
    expect_grant(0, 4, 10, 14'h0123, 24'd8);
    expect_grant(1, 17, 10, 14'h2345, 24'd9);
    expect_grant(0, 30, 10, 14'h0123, 24'd8);
    expect_grant(1, 43, 10, 14'h2345, 24'd9);
    at_cycle(4);
    check("lit_first_ack", cyc, {rd_ack, wr_ack}, 2'b10);
    at_cycle(17);
    check("lit_second_ack", cyc, {rd_ack, wr_ack}, 2'b01);

    // Read, then zero-count write, then simultaneous requests must go to read.
    at_cycle(58);
    rd_address = 14'h0456; rd_count = 24'd4; rd_len = 4; rd_todo = rd_acked + 1;
    expect_grant(0, 59, 4, 14'h0456, 24'd4);
    at_cycle(67);
    wr_address = 14'h0777; wr_count = 24'd0; wr_todo = wr_acked + 1;
    expect_grant(1, 68, 0, 14'h0777, 24'd0);
    at_cycle(68);
    check("lit_zero_wr_ack", cyc, wr_ack, 1);
    at_cycle(69);
    check("lit_zero_idle", cyc, {wr_ack, wr_en, busy}, 0);
    at_cycle(72);
    rd_address = 14'h0888; rd_count = 24'd3; rd_len = 4; rd_todo = rd_acked + 1;
    wr_address = 14'h0999; wr_count = 24'd2; wr_len = 5; wr_todo = wr_acked + 1;
    expect_grant(0, 73, 4, 14'h0888, 24'd3);
    expect_grant(1, 80, 5, 14'h0999, 24'd2);
    at_cycle(90);

    // Long write spans two expiries: late pulse, then refresh ahead of the waiting read.
    do_reset();
    at_cycle(199);
    wr_address = 14'h3FFF; wr_count = 24'd3000; wr_len = 3000; wr_todo = wr_acked + 1;
    expect_grant(1, 200, 3000, 14'h3FFF, 24'd3000);
    exp_late[3120] = 1'b1;
    expect_refresh(3203);
    expect_grant(0, 3215, 4, 14'h1111, 24'd4);
    at_cycle(1000);
    rd_address = 14'h1111; rd_count = 24'd4; rd_len = 4; rd_todo = rd_acked + 1;
    at_cycle(3120);
    check("lit_late", cyc, refresh_late, 1);
    at_cycle(3203);
    check("lit_pre_before_read", cyc, {sdram_cmd, rd_ack}, {PRE, 1'b0});
    at_cycle(3230);

    // Asynchronous reset in the middle of a read burst, then first refresh timing.
    do_reset();
    at_cycle(3);
    rd_address = 14'h2AAA; rd_count = 24'd7; rd_len = 40; rd_todo = rd_acked + 1;
    expect_grant(0, 4, 40, 14'h2AAA, 24'd7);
    at_cycle(20);
    check("lit_busy_before_rst", cyc, busy, 1);
    #2 rst = 1'b1;
    #1;
    check("async_cmd", cyc, sdram_cmd, NOP);
    check("async_busy_en", cyc, {busy, rd_en}, 0);
    check("async_latch", cyc, rd_read_address, 0);
    clear_exp();
    rd_todo = rd_acked;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    expect_refresh(1561);
    at_cycle(1561);
    check("lit_first_refresh", cyc, {sdram_cmd, sdram_addr}, {PRE, 12'h400});
    at_cycle(1580);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sdram_scheduler.md
# sdram_scheduler

Command-level scheduler for the wishbone SDRAM slave. It sits between the wishbone-side request logic and the read/write burst engines. It owns the SDRAM command/address pins and grants them to one engine at a time. It also issues periodic PRECHARGE-ALL + AUTO REFRESH sequences and alternates read/write grants round-robin so neither requester starves.

## Interface
Parameters:
- REFRESH_INTERVAL, 1560: clk cycles between refresh requests (15.6 us at 100 MHz).
- TRP, 2: NOP cycles after PRECHARGE ALL.
- TRFC, 7: NOP cycles after AUTO REFRESH.

Ports:
- clk  in  1  SDRAM clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- rd_req  in  1  level; read pending. Must hold until rd_ack.
- rd_address  in  14  {bank[1:0], row/col[11:0]}.
- rd_count  in  24  read word count.
- rd_ack  out  1  one-cycle pulse when the read request is accepted.
- wr_req, wr_address, wr_count, wr_ack: write equivalents of the read signals.
- rd_en  out  1  one-cycle start pulse to the read engine.
- rd_read_address  out  14  address latched at grant.
- rd_read_count  out  24  count latched at grant.
- rd_done  in  1  pulse from the read engine; the burst is finished and the bank is precharged.
- rd_cmd  in  4  read engine {cs_n,ras_n,cas_n,we_n}.
- rd_addr  in  12  read engine address.
- rd_bank  in  2  read engine bank.
- wr_en, wr_write_address, wr_write_count, wr_done, wr_cmd, wr_addr, wr_bank: write-engine equivalents.
- sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n} to the pins.
- sdram_addr  out  12  pin address.
- sdram_bank  out  2  pin bank.
- busy  out  1  high in every state except IDLE.
- refresh_late  out  1  one-cycle pulse when the refresh timer expires while a refresh is already pending.

## Operation
- Command encodings: NOP=4'b0111, PRECHARGE=4'b0010, AUTO REFRESH=4'b0001.
- States: IDLE, RD_START, RD_BUSY, WR_START, WR_BUSY, REF_PRE, REF_TRP, REF_AR, REF_TRFC.
- Refresh timer:
  - 16-bit down-counter loaded with REFRESH_INTERVAL-1.
  - At 0 it sets ref_pending and reloads.
  - ref_pending clears on entry to REF_PRE.
- IDLE arbitration, priority order:
  1. ref_pending -> REF_PRE.
  2. rd_req and wr_req both high -> grant the side not granted last (last_grant flag, reset = write, so read wins first).
  3. Single request -> grant it.
- Grant of read (write symmetric):
  - latch rd_address/rd_count into rd_read_*;
  - pulse rd_ack;
  - go to RD_START;
  - RD_START pulses rd_en for one cycle, then goes to RD_BUSY.
- Zero-count request: rd_ack pulses, no rd_en, last_grant updates, stay in IDLE.
- RD_BUSY / WR_BUSY:
  - sdram_cmd/addr/bank are combinationally muxed from the granted engine;
  - the state exits to IDLE on that engine's done.
  - The other engine's done is ignored.
- Refresh sequence:
  - REF_PRE drives PRECHARGE with addr[10]=1 (all banks) for 1 cycle;
  - REF_TRP drives NOP for TRP cycles;
  - REF_AR drives AUTO REFRESH for 1 cycle;
  - REF_TRFC drives NOP for TRFC cycles;
  - then IDLE.
- A refresh never preempts an active burst. It waits for done, then wins the next IDLE cycle.
- In all non-BUSY states, sdram_* come from scheduler registers. Default is NOP, addr 0, bank 0.

## Timing
- Reset values: state IDLE; sdram_cmd 4'b0111; sdram_addr 0; sdram_bank 0; rd_en, wr_en, rd_ack, wr_ack, refresh_late, busy all 0; rd/wr latched address and count 0; timer REFRESH_INTERVAL-1; ref_pending 0; last_grant write.
- Request sampled in IDLE at edge N: ack high in cycle N+1, en high in cycle N+2, engine commands on pins from N+2 onward.
- Done sampled at edge M: scheduler is in IDLE at M+1; the next grant's ack is at M+2 at the earliest.
- Refresh sequence length is 2+TRP+TRFC cycles (11 at defaults), from REF_PRE entry to IDLE.
- Timer expiry in the same cycle that ref_pending clears: ref_pending is set again (set wins).
- Timer expiry with ref_pending already set: ref_pending stays 1 and refresh_late pulses.
- rst asserted mid-burst or mid-refresh: all outputs go to reset values immediately (async). Engines are reset by the same rst.

## Test plan
- Reset mid-RD_BUSY -> sdram_cmd=4'b0111, busy=0, rd_en=0 without a clock edge; after release the first refresh occurs 1560 cycles later.
- rd_req alone, address 14'h1ABC, count 5 -> rd_ack at +1, rd_en at +2 with rd_read_address=14'h1ABC, rd_read_count=5; pins follow rd_cmd until rd_done.
- rd_req and wr_req held continuously, engines return done 10 cycles after en -> grants alternate R,W,R,W; rd_ack fires first.
- Idle with REFRESH_INTERVAL=20 -> PRECHARGE with addr[10]=1, 2 NOPs, AUTO REFRESH, 7 NOPs, repeating every 20 cycles; no refresh_late.
- Timer expires during a 3000-cycle write burst (interval 1560) -> refresh_late pulses once; refresh runs immediately after wr_done, ahead of a pending rd_req.
- wr_req with wr_count=0 -> wr_ack one pulse, wr_en never asserts, state stays IDLE, the next simultaneous request grants read.
